decoder_scan_sel_gen: RTL and testbench
=======================================

Name: decoder_scan_sel_gen

Overview:
- Sequential select generator that sits directly upstream of decoder_3x8 and drives its 3-bit input `i`.
- Steps a 3-bit index through positions 0..7 for scanned one-hot outputs (LED/keypad column scan, bank rotation).
- Each position is held for a programmable dwell time.
- Supports up, down and ping-pong scan, per-position skip masking, synchronous index load and a wrap indicator.

Parameters:
- DWELL_W, 8, width of the dwell count (cycles per position = dwell+1).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; 0 freezes the scan
- mode  in  2  00 hold, 01 up, 10 down, 11 ping-pong
- dwell  in  DWELL_W  position hold time minus 1
- skip_mask  in  8  bit k=1 excludes position k from the scan
- load  in  1  synchronous load of load_val
- load_val  in  3  index to load
- sel  out  3  registered index; connects to decoder_3x8 input
- sel_valid  out  1  registered; 1 when en=1 and sel is an unmasked position
- wrap  out  1  one-cycle registered pulse on scan wrap or ping-pong reversal
- dir_dn  out  1  registered current direction (0 up, 1 down)

Behaviour:
- Reset values: sel=0, sel_valid=0, wrap=0, dir_dn=0, internal dwell_cnt=0.
- Priority each cycle: rst > load > step logic.
- load=1 (en is ignored):
  - sel<=load_val, dwell_cnt<=0, wrap<=0, dir_dn unchanged.
  - sel_valid<=en & ~skip_mask[load_val].
- Hold conditions: en=0, or mode=00, or skip_mask=8'hFF.
  - sel held; dwell_cnt<=0; wrap<=0.
  - sel_valid<=en & ~skip_mask[sel]; this is 0 when all positions are masked.
- Stepping (en=1, mode!=00, some position unmasked):
  - While dwell_cnt < dwell: dwell_cnt increments and sel is held.
  - When dwell_cnt >= dwell: advance sel, dwell_cnt<=0. Using >= means a dwell reduced mid-position takes effect next cycle.
- Up mode (forces dir_dn<=0):
  - next = first unmasked index above sel, searching circularly.
  - wrap=1 when the search passes 7->0.
- Down mode (forces dir_dn<=1):
  - next = first unmasked index below sel, searching circularly.
  - wrap=1 when the search passes 0->7.
- Ping-pong mode:
  - Search in the current dir_dn without wrapping.
  - If no unmasked index exists beyond sel in that direction: toggle dir_dn, step to the first unmasked index in the opposite direction, and pulse wrap=1.
  - dir_dn is retained from the previous mode on entry.
- Single unmasked position, any stepping mode: sel stays and wrap=1 on every dwell expiry.
- sel currently on a masked position (after load or a mask change): the next step searches from sel as normal. sel_valid=0 until the step.
- Mode, dwell and mask changes mid-dwell do not reset dwell_cnt. The new mode applies at the next advance.
- sel_valid<=en & ~skip_mask[next sel] on each update; wrap is registered together with the sel update.
- Latency:
  - Position k occupies exactly dwell+1 cycles.
  - sel changes on the clock edge following the cycle where dwell_cnt>=dwell.
- Masked-position search is combinational over 8 positions within one cycle.

Test Plan:
- Reset/up scan:
  - Stimulus: rst 2 cycles; en=1, mode=01, dwell=2, mask=00.
  - Response: sel 0,0,0,1,1,1,...,7,7,7,0. wrap=1 only in the cycle sel goes 7->0. sel_valid=1 throughout.
- Down scan with skip:
  - Stimulus: mode=10, dwell=0, mask=8'b0010_0101, start sel=7.
  - Response: sel 7,6,4,3,1,7. wrap on 1->7. Positions 0, 2 and 5 are never output.
- Ping-pong:
  - Stimulus: mode=11, dwell=0, mask=8'b1000_0001, load_val=3.
  - Response: sel 3,4,5,6,5,4,3,2,1,2. wrap pulses on the 6->5 and 1->2 steps. dir_dn toggles at each of those steps.
- Load mid-dwell:
  - Stimulus: dwell=5, dwell_cnt=3 at sel=2; pulse load with load_val=6.
  - Response: sel=6 on the next edge, then held for 6 cycles.
  - Load with en=0: sel updates, sel_valid=0.
- Boundaries:
  - mask=8'hFF with mode=01: sel frozen, sel_valid=0, wrap=0.
  - mask=8'hEF (only position 4 unmasked), dwell=1: sel stays 4, wrap every 2 cycles.
  - en=0 mid-dwell: sel held, sel_valid=0.
- Reset mid-scan plus integration:
  - Stimulus: rst at sel=5 with wrap asserted.
  - Response: next cycle sel=0, wrap=0, dir_dn=0.
  - Driving decoder_3x8 through a full up scan: out walks 8'h01 through 8'h80 in order.

Source files
------------

// File: rtl/decoder_scan_sel_gen_if.sv
// Scan select handshake bundle: control inputs from the
// host side, registered select/status back from the generator.
interface decoder_scan_sel_gen_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         skip_mask;
    logic               load;
    logic [2:0]         load_val;
    logic [2:0]         sel;
    logic               sel_valid;
    logic               wrap;
    logic               dir_dn;

    modport master (
        output en, mode, dwell, skip_mask, load, load_val,
        input  sel, sel_valid, wrap, dir_dn
    );

    modport slave (
        input  en, mode, dwell, skip_mask, load, load_val,
        output sel, sel_valid, wrap, dir_dn
    );
endinterface

// File: rtl/decoder_scan_sel_gen.sv
// Scanned 3-bit select generator feeding decoder_3x8: up/down/ping-pong
// stepping with per-position dwell, skip masking and index load.
module decoder_scan_sel_gen #(
    parameter int DWELL_W = 8
) (
    input logic clk,
    input logic rst,
    decoder_scan_sel_gen_if.slave bus
);
    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_UP   = 2'b01,
        M_DN   = 2'b10,
        M_PP   = 2'b11
    } mode_e;

    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               dir_q, dir_d;
    logic               vld_q, vld_d;

    logic [2:0] up_nxt, dn_nxt;
    logic       up_wrap, dn_wrap;
    logic       up_hit, dn_hit;
    logic       hold;
    mode_e      mode;

    assign mode = mode_e'(bus.mode);
    assign hold = !bus.en || (mode == M_HOLD) || (&bus.skip_mask);

    // Circular search both ways; the d=8 probe lands on sel itself,
    // which covers the single-unmasked-position case.
    always_comb begin
        logic [2:0] ui;
        logic [2:0] di;
        up_nxt  = sel_q;
        dn_nxt  = sel_q;
        up_wrap = 1'b0;
        dn_wrap = 1'b0;
        up_hit  = 1'b0;
        dn_hit  = 1'b0;
        ui      = sel_q;
        di      = sel_q;
        for (int d = 1; d <= 8; d++) begin
            ui = sel_q + 3'(d);
            di = sel_q - 3'(d);
            if (!up_hit && !bus.skip_mask[ui]) begin
                up_hit  = 1'b1;
                up_nxt  = ui;
                up_wrap = (4'(d) + {1'b0, sel_q}) > 4'd7;
            end
            if (!dn_hit && !bus.skip_mask[di]) begin
                dn_hit  = 1'b1;
                dn_nxt  = di;
                dn_wrap = 4'(d) > {1'b0, sel_q};
            end
        end
    end

    always_comb begin
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        dir_d  = dir_q;
        if (bus.load) begin
            sel_d = bus.load_val;
            cnt_d = '0;
        end else if (hold) begin
            cnt_d = '0;
        end else if (cnt_q < bus.dwell) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end else begin
            cnt_d = '0;
            unique case (mode)
                M_UP: begin
                    sel_d  = up_nxt;
                    wrap_d = up_wrap;
                    dir_d  = 1'b0;
                end
                M_DN: begin
                    sel_d  = dn_nxt;
                    wrap_d = dn_wrap;
                    dir_d  = 1'b1;
                end
                M_PP: begin
                    // A wrap in the current direction means nothing lies
                    // beyond sel, so bounce to the opposite search.
                    if (!dir_q) begin
                        if (up_wrap) begin
                            sel_d  = dn_nxt;
                            wrap_d = 1'b1;
                            dir_d  = 1'b1;
                        end else begin
                            sel_d = up_nxt;
                        end
                    end else begin
                        if (dn_wrap) begin
                            sel_d  = up_nxt;
                            wrap_d = 1'b1;
                            dir_d  = 1'b0;
                        end else begin
                            sel_d = dn_nxt;
                        end
                    end
                end
                M_HOLD: ;
            endcase
        end
        vld_d = bus.en & ~bus.skip_mask[sel_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            dir_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            dir_q  <= dir_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = vld_q;
    assign bus.wrap      = wrap_q;
    assign bus.dir_dn    = dir_q;
endmodule

// File: tb/tb_decoder_scan_sel_gen.sv
// Directed bench for decoder_scan_sel_gen: scan modes, load,
// masking boundaries, reset and a modelled decoder_3x8 downstream.
module tb_decoder_scan_sel_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decoder_scan_sel_gen_if #(.DWELL_W(8)) bus ();

    decoder_scan_sel_gen #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] dn_sel [6] = '{3'd6, 3'd4, 3'd3, 3'd1, 3'd7, 3'd6};
    logic       dn_wrp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] pp_sel [9] = '{3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
                               3'd3, 3'd2, 3'd1, 3'd2};
    logic       pp_wrp [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1};
    logic       pp_dir [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0};

    function automatic logic [7:0] dec3x8(input logic [2:0] i);
        return 8'h01 << i;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_idx(input logic [2:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        bus.en        = 1'b0;
        bus.mode      = 2'b00;
        bus.dwell     = 8'd0;
        bus.skip_mask = 8'h00;
        bus.load      = 1'b0;
        bus.load_val  = 3'd0;

        // reset
        tick();
        tick();
        check("rst_sel", bus.sel, 0);
        check("rst_vld", bus.sel_valid, 0);
        check("rst_wrap", bus.wrap, 0);
        check("rst_dir", bus.dir_dn, 0);

        // up scan, dwell 2
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.mode  = 2'b01;
        bus.dwell = 8'd2;
        for (int t = 1; t <= 24; t++) begin
            tick();
            e = (t / 3) % 8;
            check($sformatf("up_sel%0d", t), bus.sel, e);
            check($sformatf("up_wrap%0d", t), bus.wrap,
                  (t % 3 == 0 && e == 0) ? 1 : 0);
            check($sformatf("up_vld%0d", t), bus.sel_valid, 1);
        end

        // down scan with skips, from 7
        bus.mode      = 2'b10;
        bus.dwell     = 8'd0;
        bus.skip_mask = 8'b0010_0101;
        load_idx(3'd7);
        check("dn_load", bus.sel, 7);
        for (int t = 0; t < 6; t++) begin
            tick();
            check($sformatf("dn_sel%0d", t), bus.sel, dn_sel[t]);
            check($sformatf("dn_wrap%0d", t), bus.wrap, dn_wrp[t]);
            check($sformatf("dn_dir%0d", t), bus.dir_dn, 1);
        end

        // ping-pong; one up step first so dir starts at 0
        bus.skip_mask = 8'b1000_0001;
        bus.mode      = 2'b01;
        load_idx(3'd2);
        tick();
        check("pp_start", bus.sel, 3);
        check("pp_dir0", bus.dir_dn, 0);
        bus.mode = 2'b11;
        for (int t = 0; t < 9; t++) begin
            tick();
            check($sformatf("pp_sel%0d", t), bus.sel, pp_sel[t]);
            check($sformatf("pp_wrap%0d", t), bus.wrap, pp_wrp[t]);
            check($sformatf("pp_dir%0d", t), bus.dir_dn, pp_dir[t]);
        end

        // load mid-dwell
        bus.mode      = 2'b01;
        bus.skip_mask = 8'h00;
        bus.dwell     = 8'd5;
        load_idx(3'd2);
        tick();
        tick();
        tick();
        check("ld_pre", bus.sel, 2);
        load_idx(3'd6);
        check("ld_sel", bus.sel, 6);
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("ld_hold%0d", t), bus.sel, 6);
        end
        tick();
        check("ld_adv", bus.sel, 7);

        // load while disabled
        bus.en = 1'b0;
        load_idx(3'd1);
        check("ld_en0_sel", bus.sel, 1);
        check("ld_en0_vld", bus.sel_valid, 0);

        // all positions masked
        bus.en        = 1'b1;
        bus.dwell     = 8'd0;
        bus.skip_mask = 8'hFF;
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("ff_sel%0d", t), bus.sel, 1);
            check($sformatf("ff_vld%0d", t), bus.sel_valid, 0);
            check($sformatf("ff_wrap%0d", t), bus.wrap, 0);
        end

        // only position 4 unmasked, dwell 1
        bus.skip_mask = 8'hEF;
        bus.dwell     = 8'd1;
        load_idx(3'd4);
        for (int t = 1; t <= 6; t++) begin
            tick();
            check($sformatf("one_sel%0d", t), bus.sel, 4);
            check($sformatf("one_wrap%0d", t), bus.wrap, t % 2 == 0);
            check($sformatf("one_vld%0d", t), bus.sel_valid, 1);
        end

        // en dropped mid-dwell
        bus.skip_mask = 8'h00;
        bus.dwell     = 8'd3;
        load_idx(3'd2);
        tick();
        bus.en = 1'b0;
        tick();
        check("en0_sel", bus.sel, 2);
        check("en0_vld", bus.sel_valid, 0);
        tick();
        check("en0_sel2", bus.sel, 2);
        bus.en = 1'b1;
        tick();
        check("en1_vld", bus.sel_valid, 1);
        check("en1_sel", bus.sel, 2);

        // reset while wrap is asserted at sel=5, dir down
        bus.mode      = 2'b10;
        bus.dwell     = 8'd0;
        bus.skip_mask = 8'hDF;
        load_idx(3'd5);
        tick();
        check("pre_rst_sel", bus.sel, 5);
        check("pre_rst_wrap", bus.wrap, 1);
        check("pre_rst_dir", bus.dir_dn, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_sel", bus.sel, 0);
        check("mid_rst_wrap", bus.wrap, 0);
        check("mid_rst_dir", bus.dir_dn, 0);
        check("mid_rst_vld", bus.sel_valid, 0);

        // full up scan through the decoder
        rst           = 1'b0;
        bus.mode      = 2'b01;
        bus.skip_mask = 8'h00;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("dec%0d", t), dec3x8(bus.sel),
                  32'(8'h01 << (t % 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
